// File: rtl/ir_dram_loader_if.sv
// ir_dram_loader_if
//   Host command channel and DRAM write-port bundle for ir_dram_loader.
//   master : host / diagnostic side (drives commands, observes DRAM port and status)
//   slave  : the loader itself
// Signals
//   cmd_valid  host has a command
//   cmd_ready  loader accepts the command on this rising edge
//   cmd_op     3-bit opcode
//   cmd_data   9-bit operand; cmd_data[8] is operand bit 0 (MSB-first numbering)
//   dram_addr  DRAM write address
//   dram_din   DRAM write data {A[0:2],B[0:2],PAR,J[1:4],J[7:10]}
//   dram_we    DRAM write enable
//   busy       COMMIT sequence in progress
//   done       one-cycle pulse after the odd write
//   wrapped    sticky pair-address wrap flag
interface ir_dram_loader_if #(
  parameter int AW = 9,
  parameter int DW = 15
);
  logic          cmd_valid;
  logic          cmd_ready;
  logic [2:0]    cmd_op;
  logic [8:0]    cmd_data;
  logic [AW-1:0] dram_addr;
  logic [DW-1:0] dram_din;
  logic          dram_we;
  logic          busy;
  logic          done;
  logic          wrapped;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, dram_addr, dram_din, dram_we, busy, done, wrapped
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, dram_addr, dram_din, dram_we, busy, done, wrapped
  );
endinterface

// File: rtl/ir_dram_loader.sv
// ir_dram_loader
//   Diagnostic loader/sequencer for the IR dispatch RAM (512 x 15).
//   The host stages A/B/PAR/J fields for one even/odd DRAM pair through
//   diag commands; COMMIT writes the even entry, then the odd entry, on
//   consecutive cycles and (optionally) advances the pair address.
// Ports
//   clk    single clock (DRAM write clock domain)
//   reset  asynchronous, active-high
//   bus    ir_dram_loader_if.slave: command handshake, DRAM write port, status
// Parameters
//   DRAM_WIDTH  data word width; layout is fixed at 15 bits
//   DRAM_SIZE   number of entries; address width = $clog2(DRAM_SIZE)
//   AUTO_INC    1: pair address += 2 after each COMMIT, 0: address held
// Configuration macro
//   IR_DRAM_LOADER_PARGEN_EN  defined: PAR = ~^(other 14 bits), so every stored
//                             word has odd parity; host PAR bits are ignored.
//                             undefined: host-supplied PAR written verbatim.
// Operand bit numbering: the operand is MSB-first [0:8]; operand bit i maps
// to cmd_data[8-i], so operand[0:2] is cmd_data[8:6] and so on.
module ir_dram_loader #(
  parameter int DRAM_WIDTH = 15,
  parameter int DRAM_SIZE  = 512,
  parameter int AUTO_INC   = 1
) (
  input logic            clk,
  input logic            reset,
  ir_dram_loader_if.slave bus
);

  localparam int AW = $clog2(DRAM_SIZE);

  localparam logic [2:0] OP_SET_ADDR  = 3'b000;
  localparam logic [2:0] OP_XY_EVEN   = 3'b001;
  localparam logic [2:0] OP_XY_ODD    = 3'b010;
  localparam logic [2:0] OP_J_COMM    = 3'b011;
  localparam logic [2:0] OP_J_EVEN    = 3'b100;
  localparam logic [2:0] OP_J_ODD     = 3'b101;
  localparam logic [2:0] OP_COMMIT    = 3'b110;
  localparam logic [2:0] OP_CLEAR     = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_EVEN = 2'd1,
    WR_ODD  = 2'd2,
    DONE    = 2'd3
  } state_e;

  state_e state;

  // pair base address (always even) and sticky wrap flag
  logic [AW-1:0] base;
  logic          wrapped_q;

  // staging fields for the pair
  logic [2:0] even_a, even_b, odd_a, odd_b;
  logic [3:0] jc, even_j, odd_j;
`ifndef IR_DRAM_LOADER_PARGEN_EN
  logic       even_p, odd_p;
`endif
  logic       even_par, odd_par;

  // registered outputs
  logic                  we_q;
  logic [AW-1:0]         addr_q;
  logic [DRAM_WIDTH-1:0] din_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  ready_q;

  // next pair address after a COMMIT; wraps naturally at the power-of-two size
  logic [AW-1:0] base_next;
  logic          base_at_top;

  always_comb begin
    base_next   = base + AW'(2);
    base_at_top = (base == AW'(DRAM_SIZE - 2));
  end

  // parity bit written into each entry
  always_comb begin
`ifdef IR_DRAM_LOADER_PARGEN_EN
    even_par = ~^{even_a, even_b, jc, even_j};
    odd_par  = ~^{odd_a, odd_b, jc, odd_j};
`else
    even_par = even_p;
    odd_par  = odd_p;
`endif
  end

  logic [DRAM_WIDTH-1:0] even_word, odd_word;

  always_comb begin
    even_word = {even_a, even_b, even_par, jc, even_j};
    odd_word  = {odd_a, odd_b, odd_par, jc, odd_j};
  end

  // Single sequential block: FSM, staging registers and registered outputs.
  // cmd_ready is high exactly in IDLE, so a command can only be accepted there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      base      <= '0;
      wrapped_q <= 1'b0;
      even_a    <= '0;
      even_b    <= '0;
      odd_a     <= '0;
      odd_b     <= '0;
      jc        <= '0;
      even_j    <= '0;
      odd_j     <= '0;
`ifndef IR_DRAM_LOADER_PARGEN_EN
      even_p    <= 1'b0;
      odd_p     <= 1'b0;
`endif
      we_q      <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            case (bus.cmd_op)
              OP_SET_ADDR: begin
                // operand bit 8 is dropped: base is always the even entry
                base      <= {bus.cmd_data[8:1], 1'b0};
                addr_q    <= {bus.cmd_data[8:1], 1'b0};
                wrapped_q <= 1'b0;
              end
              OP_XY_EVEN: begin
                even_a <= bus.cmd_data[8:6];
                even_b <= bus.cmd_data[5:3];
`ifndef IR_DRAM_LOADER_PARGEN_EN
                even_p <= bus.cmd_data[2];
`endif
              end
              OP_XY_ODD: begin
                odd_a <= bus.cmd_data[8:6];
                odd_b <= bus.cmd_data[5:3];
`ifndef IR_DRAM_LOADER_PARGEN_EN
                odd_p <= bus.cmd_data[2];
`endif
              end
              OP_J_COMM: jc     <= bus.cmd_data[8:5];
              OP_J_EVEN: even_j <= bus.cmd_data[8:5];
              OP_J_ODD:  odd_j  <= bus.cmd_data[8:5];
              OP_COMMIT: begin
                // addr_q already mirrors base while idle
                state   <= WR_EVEN;
                we_q    <= 1'b1;
                din_q   <= even_word;
                busy_q  <= 1'b1;
                ready_q <= 1'b0;
              end
              OP_CLEAR: begin
                even_a <= '0;
                even_b <= '0;
                odd_a  <= '0;
                odd_b  <= '0;
                jc     <= '0;
                even_j <= '0;
                odd_j  <= '0;
`ifndef IR_DRAM_LOADER_PARGEN_EN
                even_p <= 1'b0;
                odd_p  <= 1'b0;
`endif
              end
              default: ;
            endcase
          end
        end
        WR_EVEN: begin
          state  <= WR_ODD;
          addr_q <= {base[AW-1:1], 1'b1};
          din_q  <= odd_word;
        end
        WR_ODD: begin
          state  <= DONE;
          we_q   <= 1'b0;
          addr_q <= base;
          din_q  <= '0;
          done_q <= 1'b1;
        end
        DONE: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          if (AUTO_INC != 0) begin
            base   <= base_next;
            addr_q <= base_next;
            if (base_at_top) wrapped_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.dram_addr = addr_q;
  assign bus.dram_din  = din_q;
  assign bus.dram_we   = we_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrapped   = wrapped_q;

endmodule

// File: tb/tb_ir_dram_loader.sv
// tb_ir_dram_loader
//   Two loaders (AUTO_INC=1 and AUTO_INC=0) share one command stream.
//   A transaction-level model predicts every cycle's outputs for both; a
//   directed sequence pins the model with hand-computed values, then a
//   randomized phase exercises command mixes, wraps and resets.
`timescale 1ns/1ps
module tb_ir_dram_loader;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ir_dram_loader_if a_if ();
  ir_dram_loader_if h_if ();

  assign h_if.cmd_valid = a_if.cmd_valid;
  assign h_if.cmd_op    = a_if.cmd_op;
  assign h_if.cmd_data  = a_if.cmd_data;

  ir_dram_loader #(.AUTO_INC(1)) dut_a (.clk(clk), .reset(reset), .bus(a_if));
  ir_dram_loader #(.AUTO_INC(0)) dut_h (.clk(clk), .reset(reset), .bus(h_if));

`ifdef IR_DRAM_LOADER_PARGEN_EN
  localparam logic [14:0] EVEN_LIT = 15'h54A3;
  localparam logic [14:0] ZERO_EV  = 15'h0100;
`else
  localparam logic [14:0] EVEN_LIT = 15'h55A3;
  localparam logic [14:0] ZERO_EV  = 15'h0000;
`endif
  localparam logic [14:0] ODD_LIT  = 15'h38AC;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // Per cycle expectation; index 0 = AUTO_INC=1 instance, 1 = AUTO_INC=0.
  typedef struct packed {
    logic            we;
    logic [1:0][8:0] addr;
    logic [14:0]     din;
    logic            busy;
    logic            done;
    logic [1:0]      wr;
    logic            ready;
  } rec_t;

  rec_t q[$];
  rec_t cur;
  logic [2:0] s_a[2];
  logic [2:0] s_b[2];
  logic       s_p[2];
  logic [3:0] s_j[2];
  logic [3:0] s_jc;
  logic [8:0] mbase[2];
  logic       mwr[2];

  function automatic logic [14:0] word(input int k);
    logic p;
`ifdef IR_DRAM_LOADER_PARGEN_EN
    p = ~^{s_a[k], s_b[k], s_jc, s_j[k]};
`else
    p = s_p[k];
`endif
    return {s_a[k], s_b[k], p, s_jc, s_j[k]};
  endfunction

  function automatic rec_t mk(input logic we, input logic [8:0] a0, input logic [8:0] a1,
                              input logic [14:0] din, input logic busy, input logic done);
    rec_t r;
    r.we = we; r.addr[0] = a0; r.addr[1] = a1; r.din = din;
    r.busy = busy; r.done = done; r.wr = {mwr[1], mwr[0]}; r.ready = !busy;
    return r;
  endfunction

  task automatic clear_stage();
    for (int k = 0; k < 2; k++) begin
      s_a[k] = 0; s_b[k] = 0; s_p[k] = 0; s_j[k] = 0;
    end
    s_jc = 0;
  endtask

  task automatic apply(input logic [2:0] op, input logic [8:0] d);
    case (op)
      3'd0: for (int k = 0; k < 2; k++) begin mbase[k] = {d[8:1], 1'b0}; mwr[k] = 0; end
      3'd1: begin s_a[0] = d[8:6]; s_b[0] = d[5:3]; s_p[0] = d[2]; end
      3'd2: begin s_a[1] = d[8:6]; s_b[1] = d[5:3]; s_p[1] = d[2]; end
      3'd3: s_jc = d[8:5];
      3'd4: s_j[0] = d[8:5];
      3'd5: s_j[1] = d[8:5];
      3'd6: begin
        q.push_back(mk(1, mbase[0], mbase[1], word(0), 1, 0));
        q.push_back(mk(1, mbase[0] | 9'd1, mbase[1] | 9'd1, word(1), 1, 0));
        q.push_back(mk(0, mbase[0], mbase[1], 15'd0, 1, 1));
        if (mbase[0] == 9'd510) mwr[0] = 1;
        mbase[0] = mbase[0] + 9'd2;
      end
      default: clear_stage();
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      clear_stage();
      for (int k = 0; k < 2; k++) begin mbase[k] = 0; mwr[k] = 0; end
      cur = mk(0, 0, 0, 0, 0, 0);
    end else begin
      if (a_if.cmd_valid && cur.ready) apply(a_if.cmd_op, a_if.cmd_data);
      if (q.size() > 0) cur = q.pop_front();
      else cur = mk(0, mbase[0], mbase[1], 0, 0, 0);
    end
    #1;
    chk("a.we",      a_if.dram_we,   cur.we);
    chk("a.addr",    a_if.dram_addr, cur.addr[0]);
    chk("a.din",     a_if.dram_din,  cur.din);
    chk("a.busy",    a_if.busy,      cur.busy);
    chk("a.done",    a_if.done,      cur.done);
    chk("a.wrapped", a_if.wrapped,   cur.wr[0]);
    chk("a.ready",   a_if.cmd_ready, cur.ready);
    chk("h.we",      h_if.dram_we,   cur.we);
    chk("h.addr",    h_if.dram_addr, cur.addr[1]);
    chk("h.din",     h_if.dram_din,  cur.din);
    chk("h.wrapped", h_if.wrapped,   cur.wr[1]);
    chk("h.ready",   h_if.cmd_ready, cur.ready);
  end

  // ---------------- stimulus ----------------
  // Returns at the negedge right after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [8:0] d);
    int n;
    n = 0;
    @(negedge clk);
    a_if.cmd_valid = 1; a_if.cmd_op = op; a_if.cmd_data = d;
    while (!a_if.cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL handshake_timeout got=ready_low expected=ready_high t=%0t", $time);
    end
    @(negedge clk);
    a_if.cmd_valid = 0;
  endtask

  initial begin
    a_if.cmd_valid = 0; a_if.cmd_op = 0; a_if.cmd_data = 0;
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    chk("rst.ready", a_if.cmd_ready, 1);
    chk("rst.we",    a_if.dram_we,   0);
    chk("rst.addr",  a_if.dram_addr, 0);
    chk("rst.busy",  a_if.busy,      0);

    // full pair load and commit
    send(3'd0, 9'o104);
    send(3'd1, {7'b101_010_1, 2'b00});
    send(3'd2, {7'b011_100_0, 2'b00});
    send(3'd3, {4'hA, 5'd0});
    send(3'd4, {4'h3, 5'd0});
    send(3'd5, {4'hC, 5'd0});
    send(3'd6, 9'd0);
    chk("t2.even_we",   a_if.dram_we,   1);
    chk("t2.even_addr", a_if.dram_addr, 9'o104);
    chk("t2.even_din",  a_if.dram_din,  EVEN_LIT);
    @(negedge clk);
    chk("t2.odd_addr",  a_if.dram_addr, 9'o105);
    chk("t2.odd_din",   a_if.dram_din,  ODD_LIT);
    @(negedge clk);
    chk("t2.done",      a_if.done,      1);
    chk("t2.done_we",   a_if.dram_we,   0);
    @(negedge clk);
    chk("t2.base",      a_if.dram_addr, 9'o106);
    chk("t6.base_held", h_if.dram_addr, 9'o104);

    // repeated commit: held-address instance rewrites the same pair
    send(3'd6, 9'd0);
    chk("t6.h_even", h_if.dram_addr, 9'o104);
    chk("t6.a_even", a_if.dram_addr, 9'o106);
    @(negedge clk);
    chk("t6.h_odd",  h_if.dram_addr, 9'o105);
    repeat (2) @(negedge clk);

    // wrap at the top pair
    send(3'd0, 9'o776);
    send(3'd6, 9'd0);
    chk("t3.even_addr", a_if.dram_addr, 9'o776);
    @(negedge clk);
    chk("t3.odd_addr",  a_if.dram_addr, 9'o777);
    repeat (2) @(negedge clk);
    chk("t3.base0",     a_if.dram_addr, 9'd0);
    chk("t3.wrapped",   a_if.wrapped,   1);
    send(3'd0, 9'd0);
    chk("t3.wrap_clr",  a_if.wrapped,   0);

    // COMMIT then CLEAR held on the bus: CLEAR waits for ready
    @(negedge clk);
    a_if.cmd_valid = 1; a_if.cmd_op = 3'd6; a_if.cmd_data = 0;
    @(negedge clk);
    a_if.cmd_op = 3'd7;
    chk("t4.din_pre_clear", a_if.dram_din, EVEN_LIT);
    chk("t4.ready_n1", a_if.cmd_ready, 0);
    @(negedge clk);
    chk("t4.ready_n2", a_if.cmd_ready, 0);
    @(negedge clk);
    chk("t4.ready_n3", a_if.cmd_ready, 0);
    @(negedge clk);
    chk("t4.ready_n4", a_if.cmd_ready, 1);
    @(negedge clk);
    a_if.cmd_valid = 0;

    // cleared staging: parity behaviour, then reset mid odd write
    send(3'd6, 9'd0);
    chk("t5.zero_even_din", a_if.dram_din, ZERO_EV);
    @(negedge clk);
    chk("t1.in_odd", a_if.dram_we, 1);
    #2 reset = 1;
    #1;
    chk("t1.we_async_a", a_if.dram_we, 0);
    chk("t1.we_async_h", h_if.dram_we, 0);
    @(negedge clk);
    reset = 0;
    chk("t1.busy",  a_if.busy,      0);
    chk("t1.ready", a_if.cmd_ready, 1);
    chk("t1.base",  a_if.dram_addr, 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        reset = 1;
        @(negedge clk);
        reset = 0;
      end
      a_if.cmd_valid = 1'($urandom_range(0, 1));
      a_if.cmd_op    = 3'($urandom_range(0, 7));
      a_if.cmd_data  = 9'($urandom);
      if (a_if.cmd_op == 3'd0 && $urandom_range(0, 2) == 0)
        a_if.cmd_data = 9'($urandom_range(500, 511));
    end
    @(negedge clk);
    a_if.cmd_valid = 0;
    repeat (6) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
